// File: rtl/video_timing_gen_scaled.sv
// rtl/video_timing_gen_scaled.sv - raster timing generator with scaled render coordinates and CE strobe
// Option macro VIDEO_TIMING_SYNC_DELAY_EN delays hs/vs/ad by SYNC_DELAY cycles.
module video_timing_gen_scaled #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int FPS         = 60,
  parameter int SCALE_SHIFT = 2,
  parameter int CE_SHIFT    = 1,
  parameter int SYNC_DELAY  = 2,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int VW         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
  localparam int FW         = (FPS > 1) ? $clog2(FPS) : 1
) (
  input  logic          clk_pixel_in,
  input  logic          rst_n_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out,
  output logic [HW-1:0] sx_out,
  output logic [VW-1:0] sy_out,
  output logic          ce_out
);

`ifdef VIDEO_TIMING_SYNC_DELAY_EN
  localparam int DLY_EN = 1;
`else
  localparam int DLY_EN = 0;
`endif
  localparam int DLY = SYNC_DELAY * DLY_EN;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FPS - 1);
  localparam logic [HW-1:0] CE_MASK = HW'((1 << CE_SHIFT) - 1);

  logic [HW-1:0] hcount_q, hcount_d, sx_q, sx_d;
  logic [VW-1:0] vcount_q, vcount_d, sy_q, sy_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          nf_q, nf_d, ce_q, ce_d;
  logic          ad_q, ad_d, hs_q, hs_d, vs_q, vs_d;

  // Every output is decoded from the next counter values so it registers in step with them.
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    nf_d = (32'(hcount_d) == H_ACTIVE) && (32'(vcount_d) == V_ACTIVE);
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
    ad_d = (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
    hs_d = ((32'(hcount_d) >= H_ACTIVE + H_FP) &&
            (32'(hcount_d) <  H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs_d = ((32'(vcount_d) >= V_ACTIVE + V_FP) &&
            (32'(vcount_d) <  V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    ce_d = ((hcount_d & CE_MASK) == '0);
    sx_d = hcount_d >> SCALE_SHIFT;
    sy_d = vcount_d >> SCALE_SHIFT;
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      fc_q     <= '0;
      nf_q     <= 1'b0;
      ce_q     <= 1'b0;
      ad_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      sx_q     <= H_LAST >> SCALE_SHIFT;
      sy_q     <= V_LAST >> SCALE_SHIFT;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      fc_q     <= fc_d;
      nf_q     <= nf_d;
      ce_q     <= ce_d;
      ad_q     <= ad_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;
  assign ce_out     = ce_q;
  assign sx_out     = sx_q;
  assign sy_out     = sy_q;

  generate
    if (DLY == 0) begin : g_direct
      assign ad_out = ad_q;
      assign hs_out = hs_q;
      assign vs_out = vs_q;
    end else begin : g_delay
      // {ad, hs, vs} trail the counters by DLY cycles to match the renderer pipeline.
      logic [2:0] pipe_q [DLY];
      always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
          for (int i = 0; i < DLY; i++) pipe_q[i] <= {1'b0, ~HS_POL, ~VS_POL};
        end else begin
          pipe_q[0] <= {ad_q, hs_q, vs_q};
          for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign {ad_out, hs_out, vs_out} = pipe_q[DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen_scaled.sv
// tb/tb_video_timing_gen_scaled.sv - scoreboard bench for video_timing_gen_scaled on a reduced raster
module tb_video_timing_gen_scaled;
  localparam int HA = 16, HF = 4, HSY = 3, HB = 5;
  localparam int VA = 10, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FPS = 4, SS = 2, CES = 1, SD = 2;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int HW = $clog2(HT), VW = $clog2(VT), FW = $clog2(FPS);
`ifdef VIDEO_TIMING_SYNC_DELAY_EN
  localparam int DLY = SD;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          ad, hs, vs, nf, ce;
    logic [FW-1:0] fc;
    logic [HW-1:0] sx;
    logic [VW-1:0] sy;
  } exp_t;

  logic          clk, rst_n;
  logic [HW-1:0] hcount, sx;
  logic [VW-1:0] vcount, sy;
  logic          hs, vs, ad, nf, ce;
  logic [FW-1:0] fc;

  exp_t       sb_q[$];
  logic [2:0] dly_q[$];
  int         n_checks = 0, n_err = 0;
  int         mh, mv, mfc, exp_nf = 0, obs_nf = 0;
  exp_t       m_e, o_e;
  logic [2:0] m_raw;
  bit         found;

  video_timing_gen_scaled #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HPOL), .VS_POL(VPOL), .FPS(FPS), .SCALE_SHIFT(SS),
    .CE_SHIFT(CES), .SYNC_DELAY(SD)
  ) dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n),
    .hcount_out(hcount), .vcount_out(vcount),
    .hs_out(hs), .vs_out(vs), .ad_out(ad), .nf_out(nf),
    .fc_out(fc), .sx_out(sx), .sy_out(sy), .ce_out(ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference raster model: one expected output set per clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mh = HT - 1; mv = VT - 1; mfc = 0;
      dly_q.delete();
      repeat (DLY) dly_q.push_back({1'b0, ~HPOL, ~VPOL});
      m_e.nf = 1'b0; m_e.ce = 1'b0;
      {m_e.ad, m_e.hs, m_e.vs} = {1'b0, ~HPOL, ~VPOL};
    end else begin
      mh = (mh + 1) % HT;
      if (mh == 0) mv = (mv + 1) % VT;
      m_e.nf = (mh == HA) && (mv == VA);
      if (m_e.nf) begin
        mfc = (mfc + 1) % FPS;
        exp_nf++;
      end
      m_raw[2] = (mh < HA) && (mv < VA);
      m_raw[1] = (mh >= HA + HF && mh < HA + HF + HSY) ? HPOL : ~HPOL;
      m_raw[0] = (mv >= VA + VF && mv < VA + VF + VSY) ? VPOL : ~VPOL;
      if (DLY > 0) begin
        dly_q.push_back(m_raw);
        {m_e.ad, m_e.hs, m_e.vs} = dly_q.pop_front();
      end else begin
        {m_e.ad, m_e.hs, m_e.vs} = m_raw;
      end
      m_e.ce = (mh % (1 << CES)) == 0;
    end
    m_e.h  = HW'(mh);
    m_e.v  = VW'(mv);
    m_e.fc = FW'(mfc);
    m_e.sx = HW'(mh >> SS);
    m_e.sy = VW'(mv >> SS);
    sb_q.push_back(m_e);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      o_e = sb_q.pop_front();
      chk("hcount", 32'(hcount), 32'(o_e.h));
      chk("vcount", 32'(vcount), 32'(o_e.v));
      chk("ad",     32'(ad),     32'(o_e.ad));
      chk("hs",     32'(hs),     32'(o_e.hs));
      chk("vs",     32'(vs),     32'(o_e.vs));
      chk("nf",     32'(nf),     32'(o_e.nf));
      chk("fc",     32'(fc),     32'(o_e.fc));
      chk("ce",     32'(ce),     32'(o_e.ce));
      chk("sx",     32'(sx),     32'(o_e.sx));
      chk("sy",     32'(sy),     32'(o_e.sy));
      if (nf === 1'b1) obs_nf++;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_hcount", 32'(hcount), 32'(HT - 1));
    chk("reset_vcount", 32'(vcount), 32'(VT - 1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_h0", 32'(hcount), 32'd0);
    chk("first_ad", 32'(ad), (DLY == 0) ? 32'd1 : 32'd0);
    repeat (5 * HT * VT) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < HT * VT + 2 && !found; i++) begin
      @(negedge clk);
      if (hcount == HW'(10) && vcount == VW'(6)) found = 1'b1;
    end
    chk("reset_point_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midframe_restart_h", 32'(hcount), 32'd0);
    chk("midframe_restart_fc", 32'(fc), 32'd0);
    repeat (2 * HT * VT) @(negedge clk);
    chk("nf_pulse_count", 32'(obs_nf), 32'(exp_nf));
    chk("nf_pulses_seen", 32'(obs_nf >= FPS + 2), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
